end_screen_ctrl: RTL and testbench

//  Sequences the end-of-game overlay. Tracks game phase from game-logic events.

---
 rtl/end_screen_ctrl.sv | 163 ++++++++++++++++
 tb/tb_end_screen_ctrl.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/end_screen_ctrl.sv
// End-of-game overlay sequencer: tracks game phase, blinks the result text on
// frame ticks, freezes the score and runs the restart req/ack handshake.
module end_screen_ctrl #(
    parameter int BLINK_FRAMES   = 30,
    parameter int SHOW_FRAMES    = 120,
    parameter int TIMEOUT_FRAMES = 1800,
    parameter int CNT_W          = 11
) (
    input  logic       pclk,
    input  logic       rst_n,
    input  logic       vsync_in,
    input  logic       hit_event,
    input  logic       win_event,
    input  logic       key_start,
    input  logic       restart_ack,
    input  logic [7:0] score_in,
    output logic       game_over,
    output logic       victory,
    output logic [1:0] text_sel,
    output logic [7:0] score_hold,
    output logic       restart_req,
    output logic       busy
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_START  = 2'd1,
        ST_RUN    = 2'd2,
        ST_RESULT = 2'd3
    } state_t;

    localparam int              BW         = $clog2(BLINK_FRAMES + 1);
    localparam logic [CNT_W-1:0] CNT_MAX   = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] SHOW_C    = CNT_W'(SHOW_FRAMES);
    localparam logic [CNT_W-1:0] TMO_C     = CNT_W'(TIMEOUT_FRAMES);
    localparam logic [BW-1:0]    BLINK_LAST = BW'(BLINK_FRAMES - 1);
    localparam logic [1:0]       TXT_TITLE = 2'd0;
    localparam logic [1:0]       TXT_NONE  = 2'd1;
    localparam logic [1:0]       TXT_LOSE  = 2'd2;
    localparam logic [1:0]       TXT_WIN   = 2'd3;

    state_t           r_state;
    logic             r_vsync_q;
    logic             r_kind_win;
    logic             r_blink_on;
    logic [CNT_W-1:0] r_frame_cnt;
    logic [BW-1:0]    r_blink_cnt;

    logic             w_tick;
    logic             w_blink_nxt;
    logic [CNT_W-1:0] w_cnt_nxt;
    logic [BW-1:0]    w_bcnt_nxt;

    // Frame tick detection and next frame/blink counters. The blink phase
    // counter wraps every BLINK_FRAMES ticks, i.e. whenever the new frame
    // count is a multiple of BLINK_FRAMES; it freezes once frame_cnt saturates.
    always_comb begin
        w_tick      = vsync_in & ~r_vsync_q;
        w_cnt_nxt   = r_frame_cnt;
        w_bcnt_nxt  = r_blink_cnt;
        w_blink_nxt = r_blink_on;
        if (w_tick && (r_frame_cnt != CNT_MAX)) begin
            w_cnt_nxt = r_frame_cnt + CNT_W'(1);
            if (r_blink_cnt == BLINK_LAST) begin
                w_bcnt_nxt  = {BW{1'b0}};
                w_blink_nxt = ~r_blink_on;
            end else begin
                w_bcnt_nxt  = r_blink_cnt + BW'(1);
                w_blink_nxt = r_blink_on;
            end
        end else begin
            w_cnt_nxt   = r_frame_cnt;
            w_bcnt_nxt  = r_blink_cnt;
            w_blink_nxt = r_blink_on;
        end
    end

    // Phase FSM with all overlay outputs registered alongside the state.
    always_ff @(posedge pclk) begin
        if (!rst_n) begin
            r_state     <= ST_IDLE;
            r_vsync_q   <= 1'b0;
            r_kind_win  <= 1'b0;
            r_blink_on  <= 1'b1;
            r_frame_cnt <= {CNT_W{1'b0}};
            r_blink_cnt <= {BW{1'b0}};
            game_over   <= 1'b0;
            victory     <= 1'b0;
            text_sel    <= TXT_TITLE;
            score_hold  <= 8'd0;
            restart_req <= 1'b0;
            busy        <= 1'b1;
        end else begin
            r_vsync_q <= vsync_in;
            case (r_state)
                ST_IDLE: begin
                    if (key_start) begin
                        r_state     <= ST_START;
                        restart_req <= 1'b1;
                    end else begin
                        r_state     <= ST_IDLE;
                    end
                end
                ST_START: begin
                    if (restart_ack) begin
                        r_state     <= ST_RUN;
                        restart_req <= 1'b0;
                        text_sel    <= TXT_NONE;
                        busy        <= 1'b0;
                    end else begin
                        restart_req <= 1'b1;
                    end
                end
                ST_RUN: begin
                    // A simultaneous hit and win resolves as a loss.
                    if (hit_event || win_event) begin
                        r_state     <= ST_RESULT;
                        r_kind_win  <= ~hit_event;
                        score_hold  <= score_in;
                        r_frame_cnt <= {CNT_W{1'b0}};
                        r_blink_cnt <= {BW{1'b0}};
                        r_blink_on  <= 1'b1;
                        text_sel    <= hit_event ? TXT_LOSE : TXT_WIN;
                        game_over   <= hit_event;
                        victory     <= ~hit_event;
                        busy        <= 1'b1;
                    end else begin
                        r_state     <= ST_RUN;
                    end
                end
                ST_RESULT: begin
                    if (key_start && (r_frame_cnt >= SHOW_C)) begin
                        r_state     <= ST_START;
                        restart_req <= 1'b1;
                        game_over   <= 1'b0;
                        victory     <= 1'b0;
                        text_sel    <= TXT_TITLE;
                    end else if (r_frame_cnt == TMO_C) begin
                        r_state     <= ST_IDLE;
                        game_over   <= 1'b0;
                        victory     <= 1'b0;
                        text_sel    <= TXT_TITLE;
                    end else begin
                        r_frame_cnt <= w_cnt_nxt;
                        r_blink_cnt <= w_bcnt_nxt;
                        r_blink_on  <= w_blink_nxt;
                        game_over   <= ~r_kind_win & w_blink_nxt;
                        victory     <= r_kind_win & w_blink_nxt;
                    end
                end
                default: begin
                    r_state     <= ST_IDLE;
                    game_over   <= 1'b0;
                    victory     <= 1'b0;
                    text_sel    <= TXT_TITLE;
                    restart_req <= 1'b0;
                    busy        <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_end_screen_ctrl.sv
// Randomized self-checking bench for end_screen_ctrl against a frame-count
// model of the overlay: flag = kind & ((frames / BLINK) even).
module tb_end_screen_ctrl;

    localparam int BLINK = 30;
    localparam int SHOW  = 120;
    localparam int TMO   = 1800;

    logic       pclk = 1'b0;
    logic       rst_n, vsync_in, hit_event, win_event, key_start, restart_ack;
    logic [7:0] score_in;
    logic       game_over, victory, restart_req, busy;
    logic [1:0] text_sel;
    logic [7:0] score_hold;

    int         n_checks = 0;
    int         n_errors = 0;
    int         m_frames;
    logic [7:0] m_score;

    end_screen_ctrl #(
        .BLINK_FRAMES(BLINK), .SHOW_FRAMES(SHOW), .TIMEOUT_FRAMES(TMO), .CNT_W(11)
    ) dut (
        .pclk(pclk), .rst_n(rst_n), .vsync_in(vsync_in), .hit_event(hit_event),
        .win_event(win_event), .key_start(key_start), .restart_ack(restart_ack),
        .score_in(score_in), .game_over(game_over), .victory(victory),
        .text_sel(text_sel), .score_hold(score_hold), .restart_req(restart_req),
        .busy(busy)
    );

    always #5 pclk = ~pclk;

    function automatic logic exp_blink(input int frames);
        return ((frames / BLINK) % 2) == 0;
    endfunction

    task automatic step();
        @(posedge pclk);
        #1;
    endtask

    task automatic frame();
        vsync_in = 1'b1;
        step();
        vsync_in = 1'b0;
        step();
        repeat ($urandom_range(0, 2)) step();
        m_frames++;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; vsync_in = 1'b0; hit_event = 1'b0; win_event = 1'b0;
        key_start = 1'b0; restart_ack = 1'b0; score_in = 8'd0;
        step(); step();
        rst_n = 1'b1;
        n_checks++;
        if ({game_over, victory, restart_req} !== 3'b000) begin
            n_errors++; $display("FAIL reset_flags got %b want 000", {game_over, victory, restart_req});
        end
        n_checks++;
        if (text_sel !== 2'd0 || busy !== 1'b1 || score_hold !== 8'd0) begin
            n_errors++; $display("FAIL reset_outs got sel=%0d busy=%b hold=%0d want 0 1 0", text_sel, busy, score_hold);
        end
    endtask

    task automatic do_start(input int ack_delay);
        key_start = 1'b1; step(); key_start = 1'b0;
        n_checks++;
        if (restart_req !== 1'b1 || busy !== 1'b1) begin
            n_errors++; $display("FAIL start_req got req=%b busy=%b want 1 1", restart_req, busy);
        end
        for (int i = 0; i < ack_delay; i++) begin
            hit_event = (i == 1); win_event = (i == 2); key_start = (i == 3);
            step();
        end
        hit_event = 1'b0; win_event = 1'b0; key_start = 1'b0;
        n_checks++;
        if (restart_req !== 1'b1) begin
            n_errors++; $display("FAIL start_hold got req=%b want 1", restart_req);
        end
        restart_ack = 1'b1; step(); restart_ack = 1'b0;
        n_checks++;
        if (restart_req !== 1'b0 || text_sel !== 2'd1 || busy !== 1'b0 || game_over !== 1'b0 || victory !== 1'b0) begin
            n_errors++; $display("FAIL run_entry got req=%b sel=%0d busy=%b go=%b vic=%b want 0 1 0 0 0",
                                 restart_req, text_sel, busy, game_over, victory);
        end
    endtask

    task automatic enter_result(input logic hit, input logic win);
        m_score = 8'($urandom);
        score_in = m_score; hit_event = hit; win_event = win;
        step();
        hit_event = 1'b0; win_event = 1'b0; score_in = 8'($urandom);
        m_frames = 0;
        n_checks++;
        if (text_sel !== (hit ? 2'd2 : 2'd3) || score_hold !== m_score || busy !== 1'b1) begin
            n_errors++; $display("FAIL result_entry got sel=%0d hold=%0d busy=%b want %0d %0d 1",
                                 text_sel, score_hold, busy, hit ? 2 : 3, m_score);
        end
        n_checks++;
        if (game_over !== hit || victory !== !hit) begin
            n_errors++; $display("FAIL result_flags got go=%b vic=%b want %b %b", game_over, victory, hit, !hit);
        end
    endtask

    task automatic test_start();
        do_start($urandom_range(5, 8));
    endtask

    task automatic test_lose();
        enter_result(1'b1, 1'b0);
        repeat (60) begin
            frame();
            n_checks++;
            if (game_over !== exp_blink(m_frames) || victory !== 1'b0) begin
                n_errors++; $display("FAIL lose_blink f=%0d got go=%b vic=%b want %b 0",
                                     m_frames, game_over, victory, exp_blink(m_frames));
            end
        end
    endtask

    task automatic test_key_gating();
        key_start = 1'b1; step(); key_start = 1'b0;
        n_checks++;
        if (restart_req !== 1'b0 || text_sel !== 2'd2) begin
            n_errors++; $display("FAIL key_early60 got req=%b sel=%0d want 0 2", restart_req, text_sel);
        end
        while (m_frames < SHOW) begin
            frame();
            if (m_frames < SHOW && $urandom_range(0, 3) == 0) begin
                key_start = 1'b1; step(); key_start = 1'b0;
                n_checks++;
                if (restart_req !== 1'b0 || text_sel !== 2'd2) begin
                    n_errors++; $display("FAIL key_early f=%0d got req=%b sel=%0d want 0 2", m_frames, restart_req, text_sel);
                end
            end
            n_checks++;
            if (game_over !== exp_blink(m_frames)) begin
                n_errors++; $display("FAIL gate_blink f=%0d got %b want %b", m_frames, game_over, exp_blink(m_frames));
            end
        end
        key_start = 1'b1; step(); key_start = 1'b0;
        n_checks++;
        if (restart_req !== 1'b1 || game_over !== 1'b0 || victory !== 1'b0 || text_sel !== 2'd0) begin
            n_errors++; $display("FAIL key_accept got req=%b go=%b vic=%b sel=%0d want 1 0 0 0",
                                 restart_req, game_over, victory, text_sel);
        end
        restart_ack = 1'b1; step(); restart_ack = 1'b0;
        n_checks++;
        if (score_hold !== m_score || text_sel !== 2'd1) begin
            n_errors++; $display("FAIL hold_kept got hold=%0d sel=%0d want %0d 1", score_hold, text_sel, m_score);
        end
    endtask

    task automatic test_priority();
        int stop_at;
        enter_result(1'b1, 1'b1);
        stop_at = SHOW + $urandom_range(0, 20);
        while (m_frames < stop_at) begin
            frame();
            n_checks++;
            if (victory !== 1'b0 || game_over !== exp_blink(m_frames) || text_sel !== 2'd2) begin
                n_errors++; $display("FAIL prio f=%0d got go=%b vic=%b sel=%0d want %b 0 2",
                                     m_frames, game_over, victory, text_sel, exp_blink(m_frames));
            end
        end
        key_start = 1'b1; step(); key_start = 1'b0;
        n_checks++;
        if (restart_req !== 1'b1) begin
            n_errors++; $display("FAIL prio_exit got req=%b want 1", restart_req);
        end
        restart_ack = 1'b1; step(); restart_ack = 1'b0;
    endtask

    task automatic test_timeout();
        enter_result(1'b0, 1'b1);
        repeat (TMO - 1) begin
            frame();
            n_checks++;
            if (victory !== exp_blink(m_frames) || game_over !== 1'b0 || text_sel !== 2'd3) begin
                n_errors++; $display("FAIL win_blink f=%0d got vic=%b go=%b sel=%0d want %b 0 3",
                                     m_frames, victory, game_over, text_sel, exp_blink(m_frames));
            end
        end
        frame();
        n_checks++;
        if (victory !== 1'b0 || game_over !== 1'b0 || text_sel !== 2'd0 || busy !== 1'b1 || restart_req !== 1'b0) begin
            n_errors++; $display("FAIL timeout got vic=%b go=%b sel=%0d busy=%b req=%b want 0 0 0 1 0",
                                 victory, game_over, text_sel, busy, restart_req);
        end
        n_checks++;
        if (score_hold !== m_score) begin
            n_errors++; $display("FAIL timeout_hold got %0d want %0d", score_hold, m_score);
        end
    endtask

    task automatic test_key_at_timeout();
        do_start($urandom_range(2, 6));
        enter_result(1'b0, 1'b1);
        repeat (TMO - 1) frame();
        vsync_in = 1'b1; step();
        m_frames++;
        key_start = 1'b1; vsync_in = 1'b0; step(); key_start = 1'b0;
        n_checks++;
        if (restart_req !== 1'b1 || text_sel !== 2'd0 || victory !== 1'b0) begin
            n_errors++; $display("FAIL key_timeout got req=%b sel=%0d vic=%b want 1 0 0", restart_req, text_sel, victory);
        end
        restart_ack = 1'b1; step(); restart_ack = 1'b0;
    endtask

    task automatic test_back_to_back();
        rst_n = 1'b0; step(); rst_n = 1'b1;
        restart_ack = 1'b1; hit_event = 1'b1; step();
        win_event = 1'b1; hit_event = 1'b0; step(); win_event = 1'b0;
        n_checks++;
        if (text_sel !== 2'd0 || busy !== 1'b1 || restart_req !== 1'b0 || victory !== 1'b0 || game_over !== 1'b0) begin
            n_errors++; $display("FAIL idle_ignore got sel=%0d busy=%b req=%b vic=%b go=%b want 0 1 0 0 0",
                                 text_sel, busy, restart_req, victory, game_over);
        end
        key_start = 1'b1; step(); key_start = 1'b0;
        n_checks++;
        if (restart_req !== 1'b1) begin
            n_errors++; $display("FAIL early_ack_req got %b want 1", restart_req);
        end
        step(); restart_ack = 1'b0;
        n_checks++;
        if (restart_req !== 1'b0 || text_sel !== 2'd1 || busy !== 1'b0) begin
            n_errors++; $display("FAIL one_cycle_start got req=%b sel=%0d busy=%b want 0 1 0", restart_req, text_sel, busy);
        end
    endtask

    task automatic test_reset_in_start();
        rst_n = 1'b0; step(); step(); rst_n = 1'b1;
        key_start = 1'b1; step(); key_start = 1'b0;
        n_checks++;
        if (restart_req !== 1'b1) begin
            n_errors++; $display("FAIL rst_start_req got %b want 1", restart_req);
        end
        rst_n = 1'b0; step(); rst_n = 1'b1;
        n_checks++;
        if (restart_req !== 1'b0 || busy !== 1'b1 || text_sel !== 2'd0) begin
            n_errors++; $display("FAIL rst_in_start got req=%b busy=%b sel=%0d want 0 1 0", restart_req, busy, text_sel);
        end
    endtask

    initial begin
        test_reset();
        test_start();
        test_lose();
        test_key_gating();
        test_priority();
        test_timeout();
        test_key_at_timeout();
        test_back_to_back();
        test_reset_in_start();
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
